// File: rtl/pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer_if
// Groups the PLL-facing and system-facing signals of the PLL lock sequencer.
//   master : the sequencer (drives PLL reset and system status, samples lock)
//   slave  : the environment (PLL + reset consumers)
// Signals:
//   pll_locked  PLL locked indication, asynchronous to refclk
//   relock_req  one-cycle request to restart the sequence
//   pll_rst     reset to the PLL, active-high
//   sys_rst_n   downstream reset, active-low
//   ready       sequencer is in RUN
//   fail        sequencer gave up after too many lock timeouts
//   lock_lost   one-cycle pulse when lock drops during RUN
//   retry_cnt   failed lock attempts since last clear
// ---------------------------------------------------------------------------
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fail,
        output lock_lost,
        output retry_cnt
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fail,
        input  lock_lost,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
// Drives the reset of the refclk-referenced system PLL, waits for lock,
// requires lock to stay stable before releasing the downstream reset, retries
// on lock timeout and flags a hard failure after MAX_RETRIES failed attempts.
// Runs entirely in the refclk domain.
// Ports:
//   refclk  in  board reference clock
//   rst     in  asynchronous-assert reset, active-low
//   pll_if  master modport of pll_lock_sequencer_if (PLL lock/reset, status)
// All outputs are registered from the next state, so they always reflect the
// current state and change one cycle after their cause.
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 3
) (
    input  logic                        refclk,
    input  logic                        rst,
    pll_lock_sequencer_if.master        pll_if
);

    localparam int RST_W = $clog2(RST_PULSE_CYC + 1);
    localparam int TMR_W = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYC + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    state_e             state_q,      state_d;
    logic [RST_W-1:0]   rst_cnt_q,    rst_cnt_d;
    logic [TMR_W-1:0]   timer_q,      timer_d;
    logic [STB_W-1:0]   stable_cnt_q, stable_cnt_d;
    logic [3:0]         retry_q,      retry_d;
    logic               locked_meta_q, locked_meta_d;
    logic               locked_s_q,    locked_s_d;
    logic               pll_rst_q,    pll_rst_d;
    logic               sys_rst_n_q,  sys_rst_n_d;
    logic               ready_q,      ready_d;
    logic               fail_q,       fail_d;
    logic               lock_lost_q,  lock_lost_d;

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_RESET_PLL;
            rst_cnt_q     <= '0;
            timer_q       <= '0;
            stable_cnt_q  <= '0;
            retry_q       <= '0;
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            timer_q       <= timer_d;
            stable_cnt_q  <= stable_cnt_d;
            retry_q       <= retry_d;
            locked_meta_q <= locked_meta_d;
            locked_s_q    <= locked_s_d;
            pll_rst_q     <= pll_rst_d;
            sys_rst_n_q   <= sys_rst_n_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    always_comb begin
        // Two-flop synchroniser for the asynchronous PLL lock; every decision
        // below uses locked_s_q only.
        locked_meta_d = pll_if.pll_locked;
        locked_s_d    = locked_meta_q;

        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        timer_d      = timer_q;
        stable_cnt_d = stable_cnt_q;
        retry_d      = retry_q;
        lock_lost_d  = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (rst_cnt_q == RST_W'(RST_PULSE_CYC - 1)) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is checked first so it wins on the timeout cycle.
                if (locked_s_q) begin
                    state_d      = S_STABLE;
                    stable_cnt_d = '0;
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    retry_d = retry_q + 4'd1;
                    if (retry_d == 4'(MAX_RETRIES)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d   = S_RESET_PLL;
                        rst_cnt_d = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                    if (stable_cnt_d == STB_W'(LOCK_STABLE_CYC)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // A lock drop takes precedence over relock_req for lock_lost.
                if (!locked_s_q || pll_if.relock_req) begin
                    state_d     = S_RESET_PLL;
                    rst_cnt_d   = '0;
                    retry_d     = '0;
                    lock_lost_d = !locked_s_q;
                end
            end
            S_FAIL: begin
                if (pll_if.relock_req) begin
                    state_d   = S_RESET_PLL;
                    rst_cnt_d = '0;
                    retry_d   = '0;
                end
            end
            default: begin
                state_d   = S_RESET_PLL;
                rst_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copy
        // matches state_q.
        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    assign pll_if.pll_rst   = pll_rst_q;
    assign pll_if.sys_rst_n = sys_rst_n_q;
    assign pll_if.ready     = ready_q;
    assign pll_if.fail      = fail_q;
    assign pll_if.lock_lost = lock_lost_q;
    assign pll_if.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Directed scenarios for the PLL lock sequencer. Each stimulus step pushes the
// output changes it must cause (cycle number + full output vector) into a
// queue; a monitor pops an entry whenever the outputs change and compares.
// Output vector: {pll_rst, sys_rst_n, ready, fail, lock_lost, retry_cnt[3:0]}
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pll_lock_sequencer_if pif ();

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (20),
        .LOCK_STABLE_CYC  (8),
        .MAX_RETRIES      (2)
    ) dut (
        .refclk (clk),
        .rst    (rst),
        .pll_if (pif)
    );

    typedef struct {
        int         at;
        logic [8:0] v;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [8:0] pk(logic p, logic s, logic r, logic f, logic l,
                                      logic [3:0] rc);
        return {p, s, r, f, l, rc};
    endfunction
    function automatic logic [8:0] o_rst(logic [3:0] rc);  return pk(1, 0, 0, 0, 0, rc); endfunction
    function automatic logic [8:0] o_wait(logic [3:0] rc); return pk(0, 0, 0, 0, 0, rc); endfunction
    function automatic logic [8:0] o_run(logic [3:0] rc);  return pk(0, 1, 1, 0, 0, rc); endfunction
    function automatic logic [8:0] o_fail(logic [3:0] rc); return pk(1, 0, 0, 1, 0, rc); endfunction
    function automatic logic [8:0] o_lost();               return pk(1, 0, 0, 0, 1, 4'd0); endfunction

    task automatic push(input int at, input logic [8:0] v, input string nm);
        exp_t e;
        e.at = at;
        e.v  = v;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    // Monitor: every change of the output vector must match the next
    // expected entry, both in value and in the cycle it appears.
    logic [8:0] prev_out = 'x;
    initial begin
        logic [8:0] cur;
        exp_t       e;
        forever begin
            @(negedge clk);
            cur = {pif.pll_rst, pif.sys_rst_n, pif.ready, pif.fail,
                   pif.lock_lost, pif.retry_cnt};
            if (cur !== prev_out) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change: got out=%b at cycle %0d, expected no change",
                             cur, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.v || cyc != e.at) begin
                        miscompares++;
                        $display("FAIL %s: got out=%b at cycle %0d, expected out=%b at cycle %0d",
                                 e.nm, cur, cyc, e.v, e.at);
                    end
                end
                prev_out = cur;
            end
        end
    end

    initial begin
        int c0, l1, d1, f1, r1, r2, l3, g, d2;
        pif.pll_locked = 1'b0;
        pif.relock_req = 1'b0;
        rst = 1'b1;
        push(1, o_rst(0), "reset_state");
        #1 rst = 1'b0;

        // 1: release, lock 5 cycles after pll_rst falls, 2+8+1 to ready
        tick(3);
        c0 = cyc;
        push(c0 + 4, o_wait(0), "t1_pll_rst_fall");
        rst = 1'b1;
        l1 = c0 + 9;
        push(l1 + 11, o_run(0), "t1_ready");
        tick_to(l1);
        pif.pll_locked = 1'b1;

        // 5 + 2: lock drop in RUN, then lock never returns -> two retries, FAIL
        tick_to(l1 + 15);
        d1 = cyc;
        push(d1 + 3,  o_lost(),  "t5_lock_lost");
        push(d1 + 4,  o_rst(0),  "t5_lost_end");
        push(d1 + 7,  o_wait(0), "t5_wait");
        push(d1 + 27, o_rst(1),  "t2_retry1");
        push(d1 + 31, o_wait(1), "t2_wait1");
        push(d1 + 51, o_fail(2), "t2_fail");
        pif.pll_locked = 1'b0;
        tick_to(d1 + 15);           // relock_req in WAIT_LOCK is ignored
        pif.relock_req = 1'b1;
        tick(1);
        pif.relock_req = 1'b0;
        tick_to(d1 + 28);           // relock_req in RESET_PLL is ignored
        pif.relock_req = 1'b1;
        tick(1);
        pif.relock_req = 1'b0;

        // 3: relock from FAIL, then lock -> RUN
        tick_to(d1 + 55);
        f1 = cyc;
        push(f1 + 1,  o_rst(0),  "t3_relock_rst");
        push(f1 + 5,  o_wait(0), "t3_wait");
        push(f1 + 18, o_run(0),  "t3_ready");
        pif.relock_req = 1'b1;
        tick(1);
        pif.relock_req = 1'b0;
        tick_to(f1 + 7);
        pif.pll_locked = 1'b1;

        // relock_req in RUN: restart without lock_lost, lock still present
        tick_to(f1 + 22);
        r1 = cyc;
        push(r1 + 1,  o_rst(0),  "run_relock_rst");
        push(r1 + 5,  o_wait(0), "run_relock_wait");
        push(r1 + 14, o_run(0),  "run_relock_ready");
        pif.relock_req = 1'b1;
        tick(1);
        pif.relock_req = 1'b0;

        // lock drop and relock_req seen on the same cycle: lock_lost still pulses
        tick_to(r1 + 18);
        r2 = cyc;
        push(r2 + 3, o_lost(),  "both_lock_lost");
        push(r2 + 4, o_rst(0),  "both_lost_end");
        push(r2 + 7, o_wait(0), "both_wait");
        pif.pll_locked = 1'b0;
        tick_to(r2 + 2);
        pif.relock_req = 1'b1;
        tick(1);
        pif.relock_req = 1'b0;

        // 4: one-cycle lock dropout at stable count 5 -> 8 fresh cycles needed
        l3 = r2 + 10;
        g  = l3 + 6;
        push(g + 12, o_run(0), "t4_ready_after_dropout");
        tick_to(l3);
        pif.pll_locked = 1'b1;
        tick_to(l3 + 4);            // relock_req in STABLE is ignored
        pif.relock_req = 1'b1;
        tick(1);
        pif.relock_req = 1'b0;
        tick_to(g);
        pif.pll_locked = 1'b0;
        tick(1);
        pif.pll_locked = 1'b1;

        // 6: async reset in WAIT_LOCK at timer 10 with retry_cnt=1
        tick_to(g + 16);
        d2 = cyc;
        push(d2 + 3,  o_lost(),  "t6_lock_lost");
        push(d2 + 4,  o_rst(0),  "t6_lost_end");
        push(d2 + 7,  o_wait(0), "t6_wait");
        push(d2 + 27, o_rst(1),  "t6_retry1");
        push(d2 + 31, o_wait(1), "t6_wait1");
        push(d2 + 41, o_rst(0),  "t6_async_reset");
        pif.pll_locked = 1'b0;
        tick_to(d2 + 41);
        rst = 1'b0;
        tick(2);
        push(d2 + 47, o_wait(0), "t6_restart_wait");
        push(d2 + 60, o_run(0),  "t6_restart_ready");
        rst = 1'b1;
        tick_to(d2 + 49);
        pif.pll_locked = 1'b1;
        tick_to(d2 + 66);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_changes: got %0d expected changes never seen (next %s at cycle %0d), required 0",
                     exp_q.size(), exp_q[0].nm, exp_q[0].at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
